result_bcd_formatter: RTL and testbench
=======================================

# result_bcd_formatter

Converts a signed binary calculator result into the four BCD digits, sign flag, operator code and NaN flag consumed by the VGA display stage. It sits directly upstream of the VGA renderer and holds the displayed values stable between results. Each accepted result runs through a multi-cycle shift-add-3 (double-dabble) conversion.

## Interface
- `IN_W`, 16: width of the two's-complement `result` input; legal range 15..24.
- `MAX_MAG`, 9999: largest magnitude the display can show.
- `CONV_STEPS`, 14: number of double-dabble iterations; must satisfy 2^CONV_STEPS > MAX_MAG.

Ports:
- `clk` in 1: system clock; all registers update on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `result`, `op_in` and `div_zero` are valid.
- `in_ready` out 1: block is idle and can accept a result.
- `result` in IN_W: signed two's-complement result.
- `op_in` in 4: operator code: 0 `+`, 1 `-`, 2 `*`, 3 `/`, 5 none.
- `div_zero` in 1: the producing operation was a divide by zero.
- `num3` out 4: thousands digit.
- `num2` out 4: hundreds digit.
- `num1` out 4: tens digit.
- `num0` out 4: units digit.
- `op` out 4: registered copy of `op_in`.
- `posneg` out 1: 1 means negative.
- `is_nan` out 1: 1 means the display shows NaN.
- `out_valid` out 1: one-cycle pulse when the display outputs update.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - `in_ready`=1.
  - On a handshake (`in_valid` & `in_ready`), capture the inputs:
    - `sign` = `result[IN_W-1]`.
    - `mag` = `|result|`, computed in IN_W+1 bits so that -2^(IN_W-1) gives the correct positive value.
    - `op_in` and `div_zero` are latched.
  - If `div_zero`, or `mag` > MAX_MAG (with the saturation feature disabled): NaN path, go straight to DONE.
  - Otherwise load a 16-bit BCD accumulator with 0, load the low CONV_STEPS bits of `mag` into the shift register, clear the step counter, and go to CONV.
- CONV, once per cycle:
  - Add 3 to each BCD nibble that is ≥5.
  - Then shift {BCD, bin} left by one.
  - Increment the step counter.
  - After CONV_STEPS iterations, go to DONE.
- DONE (lasts one cycle):
  - Load `num3..num0` from the BCD accumulator; load `op` and `posneg` = `sign` & (`mag`≠0).
  - Set `is_nan`=0, pulse `out_valid`, return to IDLE.
  - On the NaN path instead: `num3..num0`=0, `posneg`=0, `is_nan`=1, `op` still loaded.
- Zero result, including -0 after negation: `posneg`=0.
- `in_valid` while not in IDLE is ignored; there is no queueing, and the upstream block must hold its inputs until the handshake.
- Display outputs hold their last values in every cycle that is not a DONE cycle.

## Timing
- Reset values:
  - `num3..num0`=0, `op`=5, `posneg`=0, `is_nan`=0, `out_valid`=0.
  - `in_ready`=1, FSM in IDLE.
- Numeric path, with the handshake at rising edge E0:
  - CONV occupies edges E1..E(CONV_STEPS).
  - DONE occurs at edge E(CONV_STEPS+1). With the defaults that is E15: outputs update there and `out_valid` is high for the following cycle.
  - `in_ready` deasserts after E0 and reasserts after E(CONV_STEPS+1).
  - The next handshake is possible at E(CONV_STEPS+2) at the earliest.
- NaN path: outputs update and `out_valid` pulses at E1; next handshake possible at E2.
- `reset_n` asserted mid-conversion: immediately returns every output to its reset value and the FSM to IDLE; the partial result is discarded and no `out_valid` pulse is produced.
- Outputs are glitch-free registers, so the downstream stage may sample them at any pixel tick.

## Configuration
- `RESULT_BCD_SAT_EN`:
  - Defined: a magnitude above MAX_MAG is clamped to MAX_MAG (displays 9999 with the correct `posneg`), takes the numeric path, and gives `is_nan`=0. Only `div_zero` produces NaN.
  - Undefined: a magnitude above MAX_MAG takes the NaN path.

## Test plan
- Reset: `reset_n`=0 → `num`=0,0,0,0, `op`=5, `is_nan`=0, `in_ready`=1.
- `result`=1234, `op_in`=0 → at E15: `num3..num0`=1,2,3,4, `posneg`=0, `op`=0, one `out_valid` pulse; `in_ready` back to 1.
- `result`=-56, `op_in`=1 → 0,0,5,6 with `posneg`=1.
- `result`=-32768:
  - Without `RESULT_BCD_SAT_EN`: at E1 `is_nan`=1, digits 0, `posneg`=0.
  - With `RESULT_BCD_SAT_EN`: 9,9,9,9 with `posneg`=1 at E15.
- `div_zero`=1, `op_in`=3 → `is_nan`=1, `op`=3 at E1 in both builds.
- Hold `in_valid`=1 across a conversion of 42, then present 7 → first pulse shows 0,0,4,2. Assert `reset_n`=0 at E5 of the second conversion → reset values, no `out_valid` pulse.

Source files
------------

// File: rtl/result_bcd_formatter.sv
// -----------------------------------------------------------------------------
// result_bcd_formatter
//
// Turns a signed two's-complement calculator result into four BCD digits plus
// sign, operator and NaN flags for the VGA display stage. Each accepted result
// is converted with a multi-cycle shift-add-3 (double-dabble) loop. The display
// outputs are registers that only change in the single DONE cycle, so the
// renderer may sample them at any pixel tick.
//
// Optional feature macro: RESULT_BCD_SAT_EN
//   defined   : magnitudes above MAX_MAG are clamped to MAX_MAG and shown as
//               digits; only div_zero produces NaN.
//   undefined : magnitudes above MAX_MAG are shown as NaN.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   result/op_in/div_zero are valid
//   in_ready   out  idle, a result can be accepted
//   result     in   signed result, IN_W bits
//   op_in      in   operator code (0 +, 1 -, 2 *, 3 /, 5 none)
//   div_zero   in   producing operation divided by zero
//   num3..num0 out  thousands, hundreds, tens, units digits
//   op         out  operator code of the displayed result
//   posneg     out  1 = displayed value is negative
//   is_nan     out  1 = display shows NaN
//   out_valid  out  one-cycle pulse when display outputs update
// -----------------------------------------------------------------------------
module result_bcd_formatter #(
  parameter int IN_W       = 16,
  parameter int MAX_MAG    = 9999,
  parameter int CONV_STEPS = 14
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] result,
  input  logic [3:0]      op_in,
  input  logic            div_zero,
  output logic [3:0]      num3,
  output logic [3:0]      num2,
  output logic [3:0]      num1,
  output logic [3:0]      num0,
  output logic [3:0]      op,
  output logic            posneg,
  output logic            is_nan,
  output logic            out_valid
);

  localparam int            CNT_W     = $clog2(CONV_STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_STEPS - 1);
  localparam logic [IN_W:0] MAX_MAG_W = (IN_W + 1)'(MAX_MAG);
`ifdef RESULT_BCD_SAT_EN
  localparam logic [CONV_STEPS-1:0] MAX_MAG_BIN = CONV_STEPS'(MAX_MAG);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return res;
  endfunction

  state_e                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  neg_q, neg_d;         // sign & (mag != 0) of the job
  logic                  nan_q, nan_d;         // job takes the NaN path
  logic [3:0]            opl_q, opl_d;         // latched operator of the job
  logic [15:0]           bcd_q, bcd_d;
  logic [CONV_STEPS-1:0] bin_q, bin_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [15:0]           num_q, num_d;
  logic [3:0]            op_q, op_d;
  logic                  posneg_q, posneg_d;
  logic                  is_nan_q, is_nan_d;
  logic                  out_valid_q, out_valid_d;

  logic [IN_W:0]         ext_s;
  logic [IN_W:0]         mag_s;
  logic                  over_s;
  logic                  nan_take_s;
  logic [CONV_STEPS-1:0] bin_load_s;
  logic [15:0]           bcd_adj_s;

  // Magnitude is formed one bit wider so the most negative input negates cleanly.
  assign ext_s  = {result[IN_W-1], result};
  assign mag_s  = result[IN_W-1] ? (~ext_s + {{IN_W{1'b0}}, 1'b1}) : ext_s;
  assign over_s = (mag_s > MAX_MAG_W);

`ifdef RESULT_BCD_SAT_EN
  assign nan_take_s = div_zero;
  assign bin_load_s = over_s ? MAX_MAG_BIN : mag_s[CONV_STEPS-1:0];
`else
  assign nan_take_s = div_zero | over_s;
  assign bin_load_s = mag_s[CONV_STEPS-1:0];
`endif

  assign bcd_adj_s = bcd_adjust(bcd_q);

  // Next-state and datapath decode for the IDLE/CONV/DONE sequence.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    neg_d       = neg_q;
    nan_d       = nan_q;
    opl_d       = opl_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    op_d        = op_q;
    posneg_d    = posneg_q;
    is_nan_d    = is_nan_q;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_d      = result[IN_W-1] & (mag_s != {(IN_W + 1){1'b0}});
          opl_d      = op_in;
          nan_d      = nan_take_s;
          bcd_d      = 16'd0;
          bin_d      = bin_load_s;
          cnt_d      = {CNT_W{1'b0}};
          in_ready_d = 1'b0;
          if (nan_take_s) begin
            state_d = DONE;
          end else begin
            state_d = CONV;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CONV: begin
        bcd_d = {bcd_adj_s[14:0], bin_q[CONV_STEPS-1]};
        bin_d = {bin_q[CONV_STEPS-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = CONV;
        end
      end

      DONE: begin
        op_d        = opl_q;
        out_valid_d = 1'b1;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
        if (nan_q) begin
          num_d    = 16'd0;
          posneg_d = 1'b0;
          is_nan_d = 1'b1;
        end else begin
          num_d    = bcd_q;
          posneg_d = neg_q;
          is_nan_d = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any job in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      neg_q       <= 1'b0;
      nan_q       <= 1'b0;
      opl_q       <= 4'd5;
      bcd_q       <= 16'd0;
      bin_q       <= {CONV_STEPS{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      num_q       <= 16'd0;
      op_q        <= 4'd5;
      posneg_q    <= 1'b0;
      is_nan_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      neg_q       <= neg_d;
      nan_q       <= nan_d;
      opl_q       <= opl_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      op_q        <= op_d;
      posneg_q    <= posneg_d;
      is_nan_q    <= is_nan_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign num3      = num_q[15:12];
  assign num2      = num_q[11:8];
  assign num1      = num_q[7:4];
  assign num0      = num_q[3:0];
  assign op        = op_q;
  assign posneg    = posneg_q;
  assign is_nan    = is_nan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_result_bcd_formatter.sv
module tb_result_bcd_formatter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] result = 16'd0;
  logic [3:0]  op_in = 4'd5;
  logic        div_zero = 1'b0;
  logic [3:0]  num3, num2, num1, num0, op;
  logic        posneg, is_nan, out_valid;

  result_bcd_formatter dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .op_in(op_in), .div_zero(div_zero),
    .num3(num3), .num2(num2), .num1(num1), .num0(num0), .op(op),
    .posneg(posneg), .is_nan(is_nan), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] num;
    logic        pos;
    logic        nan;
  } exp_t;

  // Expected display for one result, straight from decimal arithmetic.
  function automatic exp_t ref_model(input logic [15:0] r, input logic dz);
    exp_t e;
    int v, mag;
    v = int'($signed(r));
    mag = (v < 0) ? -v : v;
    e.num = 16'd0;
    e.pos = 1'b0;
    e.nan = 1'b0;
    if (dz) begin
      e.nan = 1'b1;
    end else if (mag > 9999) begin
`ifdef RESULT_BCD_SAT_EN
      mag = 9999;
`else
      e.nan = 1'b1;
`endif
    end
    if (!e.nan) begin
      e.num = {4'((mag / 1000) % 10), 4'((mag / 100) % 10), 4'((mag / 10) % 10), 4'(mag % 10)};
      e.pos = (v < 0);
    end
    return e;
  endfunction

  // Reference model: job accepted when idle, shown 1 (NaN) or 15 (digits) edges later.
  exp_t        p_e;
  logic [3:0]  p_op;
  logic        m_busy;
  int          m_cnt;
  logic [15:0] e_num;
  logic [3:0]  e_op;
  logic        e_pos, e_nan, e_valid;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      p_e     <= '0;
      p_op    <= 4'd5;
      e_num   <= 16'd0;
      e_op    <= 4'd5;
      e_pos   <= 1'b0;
      e_nan   <= 1'b0;
      e_valid <= 1'b0;
    end else begin
      e_valid <= 1'b0;
      if (m_busy) begin
        if (m_cnt + 1 == (p_e.nan ? 1 : 15)) begin
          e_num   <= p_e.num;
          e_pos   <= p_e.pos;
          e_nan   <= p_e.nan;
          e_op    <= p_op;
          e_valid <= 1'b1;
          m_busy  <= 1'b0;
        end
        m_cnt <= m_cnt + 1;
      end else if (in_valid) begin
        p_e    <= ref_model(result, div_zero);
        p_op   <= op_in;
        m_cnt  <= 0;
        m_busy <= 1'b1;
      end
    end
  end

  // Literal expectations: mode 1 = check on the out_valid cycle, mode 2 = reset values now.
  int          pin_mode = 0;
  logic [15:0] pin_num = 16'd0;
  logic [3:0]  pin_op = 4'd5;
  logic        pin_pos = 1'b0;
  logic        pin_nan = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    n_checks++;
    if ({num3, num2, num1, num0, op, posneg, is_nan, out_valid, in_ready} !==
        {e_num, e_op, e_pos, e_nan, e_valid, ~m_busy}) begin
      n_fail++;
      $display("FAIL model t=%0t got num=%h op=%0d pos=%b nan=%b vld=%b rdy=%b exp num=%h op=%0d pos=%b nan=%b vld=%b rdy=%b",
               $time, {num3, num2, num1, num0}, op, posneg, is_nan, out_valid, in_ready,
               e_num, e_op, e_pos, e_nan, e_valid, ~m_busy);
    end
    if (pin_mode == 1 && out_valid) begin
      n_checks++;
      if ({num3, num2, num1, num0, op, posneg, is_nan} !== {pin_num, pin_op, pin_pos, pin_nan}) begin
        n_fail++;
        $display("FAIL literal t=%0t got num=%h op=%0d pos=%b nan=%b exp num=%h op=%0d pos=%b nan=%b",
                 $time, {num3, num2, num1, num0}, op, posneg, is_nan, pin_num, pin_op, pin_pos, pin_nan);
      end
    end
    if (pin_mode == 2) begin
      n_checks++;
      if ({num3, num2, num1, num0, op, posneg, is_nan, out_valid, in_ready} !==
          {16'h0000, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_vals t=%0t got num=%h op=%0d pos=%b nan=%b vld=%b rdy=%b exp 0000/5/0/0/0/1",
                 $time, {num3, num2, num1, num0}, op, posneg, is_nan, out_valid, in_ready);
      end
    end
  end

  task automatic run_txn(input logic [15:0] r, input logic [3:0] o, input logic dz);
    int k;
    k = 0;
    while (!in_ready) begin
      @(negedge clk);
      k++;
      if (k > 50) begin
        $display("FAIL in_ready_timeout got in_ready=0 for 50 cycles, exp 1");
        $fatal(1, "timeout");
      end
    end
    result   = r;
    op_in    = o;
    div_zero = dz;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid) begin
      @(negedge clk);
      k++;
      if (k > 40) begin
        $display("FAIL out_valid_timeout got no pulse in 40 cycles, exp pulse");
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic pin_txn(input logic [15:0] r, input logic [3:0] o, input logic dz,
                         input logic [15:0] xn, input logic xp, input logic xnan);
    pin_num  = xn;
    pin_op   = o;
    pin_pos  = xp;
    pin_nan  = xnan;
    pin_mode = 1;
    run_txn(r, o, dz);
    @(posedge clk);
    pin_mode = 0;
  endtask

  logic [15:0] bnd [9] = '{16'd0, 16'd9999, 16'hD8F1, 16'd10000, 16'hD8F0,
                           16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF};
  logic [3:0]  ops [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5};

  initial begin
    int k;
    logic [15:0] r;
    pin_mode = 2;
    repeat (3) @(negedge clk);
    pin_mode = 0;
    reset_n = 1'b1;
    @(negedge clk);

    pin_txn(16'd1234, 4'd0, 1'b0, 16'h1234, 1'b0, 1'b0);
    pin_txn(16'hFFC8, 4'd1, 1'b0, 16'h0056, 1'b1, 1'b0);
`ifdef RESULT_BCD_SAT_EN
    pin_txn(16'h8000, 4'd2, 1'b0, 16'h9999, 1'b1, 1'b0);
`else
    pin_txn(16'h8000, 4'd2, 1'b0, 16'h0000, 1'b0, 1'b1);
`endif
    pin_txn(16'd25, 4'd3, 1'b1, 16'h0000, 1'b0, 1'b1);
    pin_txn(16'd0, 4'd5, 1'b0, 16'h0000, 1'b0, 1'b0);

    // in_valid held through a conversion of 42, then 7, reset mid-way.
    pin_num = 16'h0042; pin_op = 4'd0; pin_pos = 1'b0; pin_nan = 1'b0; pin_mode = 1;
    result = 16'd42; op_in = 4'd0; div_zero = 1'b0; in_valid = 1'b1;
    k = 0;
    while (!out_valid) begin
      @(negedge clk);
      k++;
      if (k > 40) begin
        $display("FAIL held_timeout got no pulse in 40 cycles, exp pulse");
        $fatal(1, "timeout");
      end
    end
    result = 16'd7; op_in = 4'd1;
    @(posedge clk);
    pin_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    pin_mode = 2;
    repeat (3) @(negedge clk);
    reset_n  = 1'b1;
    pin_mode = 0;
    repeat (25) @(negedge clk);

    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 9);
      if (k < 5) begin
        r = 16'(int'($urandom_range(0, 19998)) - 9999);
      end else if (k < 7) begin
        r = 16'($urandom);
      end else if (k < 9) begin
        r = bnd[$urandom_range(0, 8)];
      end else begin
        r = 16'(int'($urandom_range(0, 40)) - 20);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(r, ops[$urandom_range(0, 4)], ($urandom_range(0, 7) == 0));
    end
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
